weight_stream_loader: RTL and testbench

Byte-serial weight loader sitting directly upstream of the feed-forward network core. It parses framed weight images arriving one byte at a time (from a UART/host bridge) and assembles them into signed words. It drives the core's weight write port (`weights_en`, layer/n/m address, data) in row-major order and validates each frame with an XOR checksum.

---
 rtl/ffnn_pkg.sv | 30 +++
 rtl/byte_word_assembler.sv | 63 ++++++
 rtl/weight_stream_loader.sv | 184 ++++++++++++++++++
 tb/tb_weight_stream_loader.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffnn_pkg.sv
// Shared constants and types for the feed-forward network weight path.
// Default network geometry, frame marker and the loader state encoding.
package ffnn_pkg;

    localparam int DEF_BITS_PER_WORD      = 32;
    localparam int DEF_INPUT_VECTOR_SIZE  = 2;
    localparam int DEF_HIDDEN_LAYER_SIZE  = 2;
    localparam int DEF_OUTPUT_VECTOR_SIZE = 1;
    localparam int DEF_BIAS_SIZE          = 1;

    localparam int L0_N = DEF_INPUT_VECTOR_SIZE + DEF_BIAS_SIZE;
    localparam int L0_M = DEF_HIDDEN_LAYER_SIZE;
    localparam int L1_N = DEF_HIDDEN_LAYER_SIZE + DEF_BIAS_SIZE;
    localparam int L1_M = DEF_OUTPUT_VECTOR_SIZE;

    localparam int         BYTES_PER_WORD = DEF_BITS_PER_WORD / 8;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAYER,
        ST_WORD,
        ST_CHECK
    } load_state_e;

    function automatic int bytes_per_word(input int bits);
        return bits / 8;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte-to-word shifter: the first byte of a word lands in the LSBs.
// Flags the byte that completes a word and presents the finished word combinationally.
module byte_word_assembler
    import ffnn_pkg::*;
#(
    parameter int WORD_W = DEF_BITS_PER_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    localparam int BPW   = bytes_per_word(WORD_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PW    = (WORD_W > 8) ? WORD_W - 8 : 1;

    // Only the bytes still waiting for their upper neighbours are stored.
    logic [PW-1:0]     partial_q, partial_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shifted;
    logic              last_byte;

    generate
        if (WORD_W > 8) begin : g_shift
            assign shifted = {byte_i, partial_q};
        end else begin : g_single
            assign shifted = byte_i;
        end
    endgenerate

    assign last_byte   = (idx_q == IDX_W'(BPW - 1));
    assign word_o      = shifted;
    assign word_done_o = byte_valid_i && last_byte && !clear_i;

    // NOTE: every always_comb output gets its default first so no latch is inferred.
    always_comb begin
        partial_d = partial_q;
        idx_d     = idx_q;
        if (clear_i) begin
            partial_d = '0;
            idx_d     = '0;
        end else if (byte_valid_i) begin
            partial_d = shifted[WORD_W-1 -: PW];
            idx_d     = last_byte ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            partial_q <= '0;
            idx_q     <= '0;
        end else begin
            partial_q <= partial_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Parses framed byte-serial weight images and writes them into the FFN core row-major.
// Frame: SYNC, LAYER, N*M little-endian words, XOR CHECK over LAYER and payload.
module weight_stream_loader
    import ffnn_pkg::*;
#(
    parameter int         BITS_PER_WORD       = DEF_BITS_PER_WORD,
    parameter int         INPUT_VECTOR_SIZE   = DEF_INPUT_VECTOR_SIZE,
    parameter int         HIDDEN_LAYER_SIZE   = DEF_HIDDEN_LAYER_SIZE,
    parameter int         OUTPUT_VECTOR_SIZE  = DEF_OUTPUT_VECTOR_SIZE,
    parameter int         BIAS_SIZE           = DEF_BIAS_SIZE,
    parameter int         CLOG2_MAX_WEIGHTS_N = 2,
    parameter int         CLOG2_MAX_WEIGHTS_M = 2,
    parameter logic [7:0] SYNC_BYTE           = DEF_SYNC_BYTE
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [7:0]                     in_byte,
    output logic                           in_ready,
    output logic                           weights_en,
    output logic                           weights_layer_address,
    output logic [CLOG2_MAX_WEIGHTS_N-1:0] weights_n_address,
    output logic [CLOG2_MAX_WEIGHTS_M-1:0] weights_m_address,
    output logic [BITS_PER_WORD-1:0]       weights_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int NW = CLOG2_MAX_WEIGHTS_N;
    localparam int MW = CLOG2_MAX_WEIGHTS_M;

    localparam logic [NW-1:0] L0_N_LAST = NW'(INPUT_VECTOR_SIZE + BIAS_SIZE - 1);
    localparam logic [MW-1:0] L0_M_LAST = MW'(HIDDEN_LAYER_SIZE - 1);
    localparam logic [NW-1:0] L1_N_LAST = NW'(HIDDEN_LAYER_SIZE + BIAS_SIZE - 1);
    localparam logic [MW-1:0] L1_M_LAST = MW'(OUTPUT_VECTOR_SIZE - 1);

    load_state_e              state_q, state_d;
    logic                     layer_q, layer_d;
    logic [NW-1:0]            n_q, n_d;
    logic [MW-1:0]            m_q, m_d;
    logic [7:0]               csum_q, csum_d;
    logic                     in_ready_q;
    logic                     wen_q, wen_d;
    logic                     wlayer_q, wlayer_d;
    logic [NW-1:0]            wn_q, wn_d;
    logic [MW-1:0]            wm_q, wm_d;
    logic [BITS_PER_WORD-1:0] wdata_q, wdata_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     accept;
    logic                     asm_valid;
    logic                     asm_clear;
    logic                     word_done;
    logic [BITS_PER_WORD-1:0] word;
    logic [NW-1:0]            n_last;
    logic [MW-1:0]            m_last;

    assign accept    = in_valid && in_ready_q;
    assign asm_valid = accept && (state_q == ST_WORD);
    assign asm_clear = accept && (state_q == ST_LAYER);
    assign n_last    = layer_q ? L1_N_LAST : L0_N_LAST;
    assign m_last    = layer_q ? L1_M_LAST : L0_M_LAST;

    byte_word_assembler #(
        .WORD_W (BITS_PER_WORD)
    ) u_assembler (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (in_byte),
        .word_o       (word),
        .word_done_o  (word_done)
    );

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        n_d      = n_q;
        m_d      = m_q;
        csum_d   = csum_q;
        wen_d    = 1'b0;
        wlayer_d = wlayer_q;
        wn_d     = wn_q;
        wm_d     = wm_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_byte == SYNC_BYTE) state_d = ST_LAYER;
                end
                ST_LAYER: begin
                    if (in_byte[7:1] == 7'd0) begin
                        layer_d = in_byte[0];
                        csum_d  = in_byte;
                        n_d     = '0;
                        m_d     = '0;
                        state_d = ST_WORD;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_WORD: begin
                    csum_d = csum_q ^ in_byte;
                    if (word_done) begin
                        wen_d    = 1'b1;
                        wlayer_d = layer_q;
                        wn_d     = n_q;
                        wm_d     = m_q;
                        wdata_d  = word;
                        // Row-major walk: m is the inner index.
                        if (m_q == m_last) begin
                            m_d = '0;
                            if (n_q == n_last) state_d = ST_CHECK;
                            else               n_d     = n_q + NW'(1);
                        end else begin
                            m_d = m_q + MW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_byte == csum_q) done_d  = 1'b1;
                    else                   error_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= 1'b0;
            n_q        <= '0;
            m_q        <= '0;
            csum_q     <= '0;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            wlayer_q   <= 1'b0;
            wn_q       <= '0;
            wm_q       <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            n_q        <= n_d;
            m_q        <= m_d;
            csum_q     <= csum_d;
            in_ready_q <= 1'b1;
            wen_q      <= wen_d;
            wlayer_q   <= wlayer_d;
            wn_q       <= wn_d;
            wm_q       <= wm_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready              = in_ready_q;
    assign weights_en            = wen_q;
    assign weights_layer_address = wlayer_q;
    assign weights_n_address     = wn_q;
    assign weights_m_address     = wm_q;
    assign weights_data          = wdata_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign error                 = error_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Self-checking bench for weight_stream_loader: frames are built from the framing rules,
// expected writes are derived from word index (n = k / M, m = k % M) and compared to a monitor log.
module tb_weight_stream_loader;

    localparam int W    = 32;
    localparam int IN   = 2;
    localparam int HID  = 2;
    localparam int OUT  = 1;
    localparam int BIAS = 1;
    localparam int L0N  = IN + BIAS;
    localparam int L0M  = HID;
    localparam int L1N  = HID + BIAS;
    localparam int L1M  = OUT;

    typedef struct packed {
        logic        layer;
        logic [1:0]  n;
        logic [1:0]  m;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        weights_en;
    logic        weights_layer_address;
    logic [1:0]  weights_n_address;
    logic [1:0]  weights_m_address;
    logic [31:0] weights_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    weight_stream_loader #(
        .BITS_PER_WORD       (W),
        .INPUT_VECTOR_SIZE   (IN),
        .HIDDEN_LAYER_SIZE   (HID),
        .OUTPUT_VECTOR_SIZE  (OUT),
        .BIAS_SIZE           (BIAS),
        .CLOG2_MAX_WEIGHTS_N (2),
        .CLOG2_MAX_WEIGHTS_M (2),
        .SYNC_BYTE           (8'hA5)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .in_valid              (in_valid),
        .in_byte               (in_byte),
        .in_ready              (in_ready),
        .weights_en            (weights_en),
        .weights_layer_address (weights_layer_address),
        .weights_n_address     (weights_n_address),
        .weights_m_address     (weights_m_address),
        .weights_data          (weights_data),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (weights_en === 1'b1)
            obs_q.push_back('{weights_layer_address, weights_n_address,
                              weights_m_address, weights_data, cyc});
        if (done === 1'b1)  done_cnt++;
        if (error === 1'b1) err_cnt++;
    end

    // Present one byte for one cycle after an optional idle gap; records its accept cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    function automatic int pick_gap(input int gapmax);
        return (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
    endfunction

    // Sends the frame for `words`, ending right after the CHECK byte is accepted.
    task automatic send_frame(input logic [7:0] layer, input int gapmax,
                              input bit corrupt, input bit with_sync);
        int          m_dim;
        logic [7:0]  cs;
        logic [31:0] w;
        logic [7:0]  v;
        m_dim = layer[0] ? L1M : L0M;
        if (with_sync) send_byte(8'hA5, pick_gap(gapmax));
        send_byte(layer, pick_gap(gapmax));
        cs = layer;
        for (int k = 0; k < words.size(); k++) begin
            w = words[k];
            for (int b = 0; b < 4; b++) begin
                v  = w[8*b +: 8];
                cs = cs ^ v;
                send_byte(v, pick_gap(gapmax));
            end
            exp_q.push_back('{layer[0], 2'(k / m_dim), 2'(k % m_dim), w, last_acc});
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs, pick_gap(gapmax));
    endtask

    task automatic random_words(input int count);
        words.delete();
        for (int k = 0; k < count; k++) words.push_back($urandom);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, weights_en, weights_layer_address, weights_n_address,
             weights_m_address, weights_data, busy, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_values got en=%b rdy=%b n=%0d m=%0d data=%h busy=%b done=%b err=%b exp all 0",
                     weights_en, in_ready, weights_n_address, weights_m_address,
                     weights_data, busy, done, error);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release got %b exp 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", in_ready);
        end
    endtask

    task automatic test_layer0_load();
        int base;
        base = obs_q.size();
        exp_q.delete();
        words = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000,
                  32'h0002_0000, 32'h0000_0000, 32'h7FFF_FFFF};
        send_frame(8'h00, 0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            errors++;
            $display("FAIL l0_status got done=%b err=%b busy=%b exp 1 0 0", done, error, busy);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL l0_write_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL l0_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({weights_en, weights_n_address, weights_m_address, weights_data} !==
            {1'b0, 2'd2, 2'd1, 32'h7FFF_FFFF}) begin
            errors++;
            $display("FAIL l0_hold got en=%b n=%0d m=%0d data=%h exp 0 2 1 7fffffff",
                     weights_en, weights_n_address, weights_m_address, weights_data);
        end
    endtask

    task automatic test_layer1_gaps();
        int base;
        base = obs_q.size();
        exp_q.delete();
        random_words(L1N * L1M);
        send_frame(8'h01, 5, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL l1_status got done=%b err=%b exp 1 0", done, error);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL l1_write_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL l1_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_junk_before_sync();
        int          base;
        logic [7:0]  junk [3];
        junk = '{8'h00, 8'h13, 8'hFF};
        base = obs_q.size();
        exp_q.delete();
        foreach (junk[j]) begin
            send_byte(junk[j], 1);
            @(negedge clk);
            checks++;
            if ({busy, weights_en} !== 2'b00) begin
                errors++;
                $display("FAIL junk_idle[%0d] got busy=%b en=%b exp 0 0", j, busy, weights_en);
            end
        end
        random_words(L0N * L0M);
        send_frame(8'h00, 1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL junk_status got done=%b err=%b exp 1 0", done, error);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL junk_write_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL junk_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bad_layer();
        int base;
        int d0;
        base = obs_q.size();
        d0   = done_cnt;
        exp_q.delete();
        send_byte(8'hA5, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL badlayer_busy_after_sync got %b exp 1", busy);
        end
        send_byte(8'h02, 0);
        @(negedge clk);
        checks++;
        if ({error, done, busy} !== 3'b100) begin
            errors++;
            $display("FAIL badlayer_status got err=%b done=%b busy=%b exp 1 0 0", error, done, busy);
        end
        // Recovery: a full valid frame follows.
        random_words(L1N * L1M);
        send_frame(8'h01, 0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL badlayer_recover got done=%b err=%b exp 1 0", done, error);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size() || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL badlayer_counts got writes=%0d dones=%0d exp %0d 1",
                     obs_q.size() - base, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_bad_check();
        int base;
        base = obs_q.size();
        exp_q.delete();
        random_words(L0N * L0M);
        send_frame(8'h00, 2, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error, busy} !== 3'b010) begin
            errors++;
            $display("FAIL badcheck_status got done=%b err=%b busy=%b exp 0 1 0", done, error, busy);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL badcheck_write_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL badcheck_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int          base;
        logic [31:0] w;
        base = obs_q.size();
        exp_q.delete();
        random_words(3);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            for (int b = 0; b < ((k < 2) ? 4 : 2); b++) send_byte(w[8*b +: 8], 0);
            if (k < 2) exp_q.push_back('{1'b0, 2'd0, 2'(k), w, last_acc});
        end
        // The third word's next byte arrives together with reset and must be dropped.
        in_valid = 1'b1;
        in_byte  = w[23:16];
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, weights_en, weights_layer_address, weights_n_address,
             weights_m_address, weights_data, busy, done, error} !== '0) begin
            errors++;
            $display("FAIL midreset_values got en=%b rdy=%b n=%0d m=%0d data=%h busy=%b exp all 0",
                     weights_en, in_ready, weights_n_address, weights_m_address, weights_data, busy);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() - base !== 2) begin
            errors++;
            $display("FAIL midreset_write_count got %0d exp 2", obs_q.size() - base);
        end
        for (int i = 0; i < 2; i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
        base = obs_q.size();
        exp_q.delete();
        random_words(L0N * L0M);
        send_frame(8'h00, 1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_reload got done=%b err=%b exp 1 0", done, error);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL midreset_reload_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_reload[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = obs_q.size();
        exp_q.delete();
        random_words(L1N * L1M);
        send_frame(8'h01, 0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_first_done got done=%b busy=%b exp 1 0", done, busy);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_second_busy got done=%b busy=%b exp 0 1", done, busy);
        end
        random_words(L0N * L0M);
        send_frame(8'h00, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second_done got done=%b err=%b exp 1 0", done, error);
        end
        checks++;
        if (obs_q.size() - base !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_write_count got %0d exp %0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                checks++;
                if (obs_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_write[%0d] got %h exp %h", i, obs_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        int         base;
        logic [7:0] layer;
        bit         bad;
        for (int f = 0; f < 8; f++) begin
            base  = obs_q.size();
            exp_q.delete();
            layer = 8'($urandom_range(1, 0));
            bad   = ($urandom_range(3, 0) == 0);
            random_words(layer[0] ? L1N * L1M : L0N * L0M);
            send_frame(layer, 3, bad, 1'b1);
            @(negedge clk);
            checks++;
            if ({done, error} !== (bad ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rand[%0d]_status got done=%b err=%b bad=%0d", f, done, error, bad);
            end
            checks++;
            if (obs_q.size() - base !== exp_q.size()) begin
                errors++;
                $display("FAIL rand[%0d]_write_count got %0d exp %0d", f, obs_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (base + i < obs_q.size()) begin
                    checks++;
                    if (obs_q[base + i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand[%0d]_write[%0d] got %h exp %h", f, i, obs_q[base + i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        test_reset();
        test_layer0_load();
        test_layer1_gaps();
        test_junk_before_sync();
        test_bad_layer();
        test_bad_check();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
